serial_pattern_tx: RTL and testbench
====================================

# serial_pattern_tx

Serial bit-pattern transmitter that drives the single-bit serial line `w` consumed by the sequence detectors (e.g. the "1111" detector). It accepts a parallel pattern plus a repetition count and shifts the pattern out MSB-first, one bit per clock. It inserts a programmable idle gap of zeros between repetitions and reports completion with a one-cycle `done` pulse. It is the stimulus/transmit end of the detector's serial interface, used both as a reusable traffic source in benches and as the on-chip pattern source.

## Interface
Parameters:
- `WIDTH`, default 8: pattern length in bits (2..32).
- `GAP_LEN`, default 1: number of `w`=0 cycles between repetitions (0 = back-to-back).
- `CNT_W`, default 4: width of the repetition count.

Ports:
- `clk`  input  1  single clock, rising-edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start`  input  1  request to transmit; sampled on rising edge while idle.
- `data`  input  WIDTH  pattern; captured when `start` is accepted.
- `count`  input  CNT_W  repetitions; captured with `data`.
- `w`  output  1  serial output line, registered.
- `busy`  output  1  high while a transmission is in progress.
- `done`  output  1  one-cycle pulse after the final bit.

## Operation
- Reset (`reset`=0) asynchronously forces `w`=0, `busy`=0, `done`=0, state IDLE, and clears internal counters. Reset mid-transmission aborts it. No `done` is produced for the aborted transfer.
- State machine: IDLE, SHIFT, GAP, FIN.
  - IDLE: `w`=0, `busy`=0. On `start`=1 with `count`≠0, capture `data` into a shadow register and a shift register, load the repetition counter with `count`, and go to SHIFT. On `start`=1 with `count`=0, go directly to FIN.
  - SHIFT: `w` = current MSB of the shift register. The shift register shifts left each cycle and the bit counter counts WIDTH cycles. After the last bit:
    - If repetitions remain and `GAP_LEN`>0, go to GAP.
    - If repetitions remain and `GAP_LEN`=0, reload the shift register from the shadow register and stay in SHIFT.
    - If no repetitions remain, go to FIN.
  - GAP: `w`=0 for `GAP_LEN` cycles, then reload the shift register from the shadow register and return to SHIFT.
  - FIN: `w`=0, `busy`=0, `done`=1 for exactly one cycle, then IDLE. `start` is also accepted in FIN and behaves as it does in IDLE.
- `start` is ignored while `busy`=1. `data` and `count` changing during a transmission have no effect.
- Counters must not wrap:
  - The repetition counter is CNT_W bits and decrements once per completed pattern.
  - The bit counter is ceil(log2(WIDTH+1)) bits.
  - The gap counter is sized for `GAP_LEN`.

## Timing
- Let edge N be the edge that samples `start`=1 while idle.
  - From edge N+i until edge N+i+1, `w` = `data[WIDTH-1-i]` of the first repetition, for i = 0..WIDTH-1.
  - `busy` rises at edge N.
- Total busy length T = `count`·WIDTH + (`count`−1)·`GAP_LEN` cycles.
  - At edge N+T, `busy`=0, `done`=1, and `w`=0.
  - At edge N+T+1, `done`=0, unless a new start was accepted at edge N+T.
- `count`=0: `busy` stays 0 throughout, `w` stays 0, and `done`=1 during the cycle after edge N.
- Back-to-back transfers: if `start`=1 at edge N+T (the FIN cycle), the new first bit appears at edge N+T+1. This gives zero idle cycles between transfers apart from the FIN cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Reset: assert `reset`=0 with `start`=1 → `w`=0, `busy`=0, `done`=0 while held. Release → remains idle until `start`.
- Single pattern: WIDTH=8, `data`=8'hF0, `count`=1 → `w` = 1,1,1,1,0,0,0,0 on successive cycles, `busy` high for 8 cycles, then one `done` pulse. A downstream "1111" detector asserts `y` exactly once.
- Repetition with gap: `data`=8'hA5, `count`=3, `GAP_LEN`=1 → `w` = 10100101,0,10100101,0,10100101. `busy` is high for 26 cycles, followed by one `done` pulse.
- Ignored start and input changes: pulse `start` with new `data` mid-transfer → the waveform is unchanged from the original pattern and there is no extra `done`.
- Abort: assert `reset`=0 at bit 3 of a `count`=2 transfer → `w`, `busy`, and `done` go to 0 immediately and no `done` follows. A fresh `start` after release transmits correctly from the MSB.
- Edge cases:
  - `count`=0 → no bits, `done` one cycle after `start`.
  - `start` held high continuously with `count`=1 → transfers of T=8 cycles separated by exactly one FIN cycle.

Source files
------------

// File: rtl/serial_pattern_tx_if.sv
// Handshake bundle between a pattern requester and serial_pattern_tx.
// Carries the start request, pattern and count, and returns the serial line and status.
interface serial_pattern_tx_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic             start;
  logic [WIDTH-1:0] data;
  logic [CNT_W-1:0] count;
  logic             w;
  logic             busy;
  logic             done;

  modport master (
    output start, data, count,
    input  w, busy, done
  );

  modport slave (
    input  start, data, count,
    output w, busy, done
  );
endinterface

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: shifts a captured pattern out MSB-first,
// repeats it with an idle gap between copies, then pulses done.
module serial_pattern_tx #(
  parameter int WIDTH   = 8,
  parameter int GAP_LEN = 1,
  parameter int CNT_W   = 4
) (
  input  logic               clk,
  input  logic               reset,
  serial_pattern_tx_if.slave bus
);

  localparam int BW = $clog2(WIDTH + 1);
  localparam int GW = (GAP_LEN > 0) ? $clog2(GAP_LEN + 1) : 1;

  typedef enum logic [1:0] {
    IDLE,
    SHIFT,
    GAP,
    FIN
  } state_t;

  state_t           state, nstate;
  logic [WIDTH-1:0] sr, nsr;
  logic [WIDTH-1:0] shadow, nshadow;
  logic [CNT_W-1:0] rep, nrep;
  logic [BW-1:0]    bitc, nbit;
  logic [GW-1:0]    gapc, ngap;
  logic             w_q, busy_q, done_q;
  logic             nw;

  always_comb begin
    nstate  = state;
    nsr     = sr;
    nshadow = shadow;
    nrep    = rep;
    nbit    = bitc;
    ngap    = gapc;
    nw      = 1'b0;
    unique case (state)
      IDLE, FIN: begin
        nstate = IDLE;
        if (bus.start) begin
          if (bus.count != '0) begin
            nstate  = SHIFT;
            nshadow = bus.data;
            nsr     = bus.data << 1;
            nw      = bus.data[WIDTH-1];
            nbit    = BW'(1);
            nrep    = bus.count;
          end else begin
            nstate = FIN;
          end
        end
      end
      SHIFT: begin
        if (bitc == BW'(WIDTH)) begin
          // rep still counts the copy that just finished
          nrep = rep - CNT_W'(1);
          if (rep == CNT_W'(1)) begin
            nstate = FIN;
          end else if (GAP_LEN > 0) begin
            nstate = GAP;
            ngap   = GW'(1);
          end else begin
            nsr  = shadow << 1;
            nw   = shadow[WIDTH-1];
            nbit = BW'(1);
          end
        end else begin
          nsr  = sr << 1;
          nw   = sr[WIDTH-1];
          nbit = bitc + BW'(1);
        end
      end
      GAP: begin
        if (gapc == GW'(GAP_LEN)) begin
          nstate = SHIFT;
          nsr    = shadow << 1;
          nw     = shadow[WIDTH-1];
          nbit   = BW'(1);
        end else begin
          ngap = gapc + GW'(1);
        end
      end
      default: nstate = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      sr     <= '0;
      shadow <= '0;
      rep    <= '0;
      bitc   <= '0;
      gapc   <= '0;
      w_q    <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      state  <= nstate;
      sr     <= nsr;
      shadow <= nshadow;
      rep    <= nrep;
      bitc   <= nbit;
      gapc   <= ngap;
      w_q    <= nw;
      busy_q <= (nstate == SHIFT) || (nstate == GAP);
      done_q <= (nstate == FIN);
    end
  end

  assign bus.w    = w_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Scoreboard bench for serial_pattern_tx: expected {w,busy,done} per cycle
// is queued at each accepted start and checked by a negedge monitor.
module tb_serial_pattern_tx;

  localparam int WIDTH   = 8;
  localparam int GAP_LEN = 1;
  localparam int CNT_W   = 4;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  int   cyc;
  logic [2:0] sb[$];

  serial_pattern_tx_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  serial_pattern_tx #(
    .WIDTH(WIDTH),
    .GAP_LEN(GAP_LEN),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .reset(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h exp=%0h", name, cyc, got, exp);
    end
  endtask

  // Expected cycle stream for one accepted start, as {w,busy,done}.
  task automatic push_xfer(input logic [WIDTH-1:0] d, input int c);
    for (int r = 0; r < c; r++) begin
      for (int i = WIDTH - 1; i >= 0; i--) sb.push_back({d[i], 2'b10});
      if (r < c - 1)
        for (int g = 0; g < GAP_LEN; g++) sb.push_back(3'b010);
    end
    sb.push_back(3'b001);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 300) begin
      @(negedge clk);
      k++;
    end
    chk("drain_timeout", sb.size(), 0);
  endtask

  task automatic send(input logic [WIDTH-1:0] d, input int c);
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.data  = d;
    bus.count = CNT_W'(c);
    @(posedge clk);
    push_xfer(d, c);
    #1;
    bus.start = 1'b0;
    bus.data  = 8'h5A;
    bus.count = CNT_W'(7);
  endtask

  always @(negedge clk) begin
    logic [2:0] e;
    cyc++;
    if (sb.size() > 0) e = sb.pop_front();
    else e = 3'b000;
    chk("out_w_busy_done", {bus.w, bus.busy, bus.done}, e);
  end

  initial begin
    checks    = 0;
    errors    = 0;
    cyc       = 0;
    rst       = 1'b1;
    bus.start = 1'b1;
    bus.data  = 8'hFF;
    bus.count = CNT_W'(1);
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_w", bus.w, 0);
    chk("reset_busy", bus.busy, 0);
    chk("reset_done", bus.done, 0);
    bus.start = 1'b0;
    @(posedge clk);
    #1 rst = 1'b1;
    repeat (3) @(posedge clk);

    // single pattern: 1111_0000
    send(8'hF0, 1);
    drain();

    // three copies with one-cycle gaps, 26 busy cycles
    send(8'hA5, 3);
    drain();

    // mid-transfer start with new data is ignored
    send(8'h3C, 2);
    repeat (4) @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.data  = 8'hFF;
    bus.count = CNT_W'(5);
    @(posedge clk);
    #1 bus.start = 1'b0;
    drain();

    // abort at bit 3 of a two-copy transfer
    send(8'hC3, 2);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
    #1;
    chk("abort_w", bus.w, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    send(8'h96, 1);
    drain();

    // zero count: only a done pulse
    send(8'hFF, 0);
    drain();

    // start held high: transfers separated by exactly one FIN cycle
    @(posedge clk);
    #1;
    bus.start = 1'b1;
    bus.data  = 8'h81;
    bus.count = CNT_W'(1);
    @(posedge clk);
    push_xfer(8'h81, 1);
    repeat (2) begin
      repeat (WIDTH + 1) @(posedge clk);
      push_xfer(8'h81, 1);
    end
    #1 bus.start = 1'b0;
    drain();

    repeat (4) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
